apf_csr_responder: RTL
======================

// Module: apf_csr_responder
// PURPOSE
//  AXI4-Lite responder terminating one APF function port (e.g. achk/pr slot) with a small CSR file.
//  Accepts single-beat reads/writes from the APF fabric, decodes a 64-bit register map
//  (DFH, scratch, control, status, access counters) and returns OKAY/SLVERR responses.
//  Sits behind the soc APF interconnect as the endpoint of an ofs_fim_axi_lite_if.slave link.
// PARAMETERS
//  ADDR_W     16                  AXI-Lite address width; byte address, 8-byte registers
//  DFH_VALUE  64'h3000_0000_1000_0000  read-only value at offset 0x00
//  CTRL_RST   64'h0               reset value of CTRL register
// PORTS
//  clk           in   1      single clock, all logic rising-edge
//  rst_n         in   1      asynchronous, active-low reset
//  csr_if        slave ofs_fim_axi_lite_if  AW/W/B/AR/R channels, DATA_W=64, ADDR_W
//  status_i      in   64     live status, returned on STATUS reads
//  ctrl_o        out  64     current CTRL register value
//  ctrl_wr_o     out  1      one-cycle pulse when CTRL is written
// BEHAVIOUR
//  Map (addr[ADDR_W-1:3], addr[2:0] ignored): 0x00 DFH RO; 0x08 SCRATCH RW; 0x10 CTRL RW;
//   0x18 STATUS RO; 0x20 CNT RO {rd_cnt[31:0],wr_cnt[31:0]}, any write clears both.
//  Unmapped offset: read -> rdata=0, rresp=SLVERR(2'b10); write -> dropped, bresp=SLVERR.
//  Write to RO reg (DFH/STATUS): dropped, bresp=OKAY.
//  RW writes honour wstrb per byte; wstrb=0 -> no change, OKAY.
//  Write path: AW and W accepted independently into one holding reg each (aw_pend, w_pend).
//   awready = !aw_pend & !bvalid; wready = !w_pend & !bvalid (registered).
//   Both pending at edge T -> register commits and bvalid=1 at T+1; bvalid/bresp held until
//   bready; on B handshake both pends clear, readies reassert next cycle. Max 1 write in flight.
//   AW and W in same cycle: latency 1 (handshake cycle T, bvalid cycle T+1).
//  Read path: arready = !rvalid. AR handshake cycle T -> rvalid=1, rdata/rresp at T+1,
//   held stable until rready; arready reasserts the cycle after R handshake.
//  Read/write same cycle, same reg: read captures pre-write value.
//  Counters: wr_cnt +1 per B handshake, rd_cnt +1 per R handshake (all offsets), wrap at 2^32.
//   Write to CNT: both clear to 0, the clearing write is not counted; R handshake same cycle -> 0 wins.
//  ctrl_wr_o: high for exactly the commit cycle of a CTRL write (also when wstrb=0).
//  Reset (async assert): awready/wready/arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0,
//   pends=0, SCRATCH=0, CTRL=CTRL_RST, counters=0, ctrl_wr_o=0; readies=1 first cycle after
//   rst_n deasserts. Reset mid-transaction aborts it; no response is issued afterwards.
//  Unused inputs awprot/arprot ignored.
// STRUCTURE
//  apf_csr_pkg: offset localparams (DFH/SCRATCH/CTRL/STATUS/CNT), RESP_OKAY/RESP_SLVERR,
//   csr_idx_e enum for decoded register index, decode function addr->csr_idx_e.
//  Sub-module apf_csr_regfile: register storage, wstrb merge, counters, read mux;
//   top holds AXI-Lite channel handshake/holding logic only.
// TESTING
//  1 Reset, read 0x00 -> rvalid 1 cycle after AR, rdata=DFH_VALUE, rresp=OKAY.
//  2 AW@T, W@T+3 to 0x08 data 64'hA5A5_..., wstrb=8'h0F -> bvalid@T+4, readback low 32b A5, high 0.
//  3 Write 0x10 = 64'h1 -> ctrl_wr_o pulses 1 cycle, ctrl_o=1; bready low 5 cycles -> bvalid held,
//    awready/wready stay 0.
//  4 Read 0x40 -> rdata=0, rresp=2'b10; write 0x40 -> bresp=2'b10, SCRATCH unchanged.
//  5 3 writes + 2 reads, read 0x20 -> {2,3} (read counted after its own handshake);
//    write 0x20 -> next read of 0x20 returns {0,0}.
//  6 rst_n low while rvalid=1 and rready=0 -> rvalid drops immediately, CTRL=CTRL_RST, no stale R.

Source files
------------

// File: rtl/apf_csr_pkg.sv
// apf_csr_pkg: shared definitions for the APF CSR responder.
//   - byte offsets of the 64-bit register map
//   - AXI-Lite response codes
//   - csr_idx_e decoded register index and the address decode function
//   - per-byte write-strobe merge helper
package apf_csr_pkg;

  localparam logic [63:0] OFF_DFH     = 64'h00;
  localparam logic [63:0] OFF_SCRATCH = 64'h08;
  localparam logic [63:0] OFF_CTRL    = 64'h10;
  localparam logic [63:0] OFF_STATUS  = 64'h18;
  localparam logic [63:0] OFF_CNT     = 64'h20;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    CsrDfh,
    CsrScratch,
    CsrCtrl,
    CsrStatus,
    CsrCnt,
    CsrNone
  } csr_idx_e;

  // Byte lane bits [2:0] never select a register; mask them before matching.
  function automatic csr_idx_e csr_decode(input logic [63:0] addr);
    logic [63:0] word;
    word = addr & ~64'h7;
    case (word)
      OFF_DFH:     return CsrDfh;
      OFF_SCRATCH: return CsrScratch;
      OFF_CTRL:    return CsrCtrl;
      OFF_STATUS:  return CsrStatus;
      OFF_CNT:     return CsrCnt;
      default:     return CsrNone;
    endcase
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ofs_fim_axi_lite_if.sv
// ofs_fim_axi_lite_if: AXI4-Lite link bundle (AW/W/B/AR/R).
//   slave modport  - endpoint view (responder)
//   master modport - initiator view
interface ofs_fim_axi_lite_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/apf_csr_regfile.sv
// apf_csr_regfile: register storage for the APF CSR responder.
//   clk, rst_n      clock, async active-low reset
//   wr_en           commit strobe for one write (wr_idx/wr_data/wr_strb valid)
//   wr_cnt_inc      count one completed write response
//   rd_cnt_inc      count one completed read response
//   rd_idx/rd_data  combinational read mux
//   status_i        live status returned on STATUS reads
//   ctrl_o          CTRL register, ctrl_wr_o pulses the cycle after a CTRL commit
module apf_csr_regfile
  import apf_csr_pkg::*;
#(
  parameter logic [63:0] DFH_VALUE = 64'h3000_0000_1000_0000,
  parameter logic [63:0] CTRL_RST  = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  csr_idx_e    wr_idx,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  input  logic        wr_cnt_inc,
  input  logic        rd_cnt_inc,
  input  csr_idx_e    rd_idx,
  output logic [63:0] rd_data,
  input  logic [63:0] status_i,
  output logic [63:0] ctrl_o,
  output logic        ctrl_wr_o
);

  logic [63:0] scratch_q, scratch_d;
  logic [63:0] ctrl_q, ctrl_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic        ctrl_wr_q, ctrl_wr_d;

  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    ctrl_wr_d = 1'b0;

    if (wr_cnt_inc) wr_cnt_d = wr_cnt_q + 32'd1;
    if (rd_cnt_inc) rd_cnt_d = rd_cnt_q + 32'd1;

    if (wr_en) begin
      unique case (wr_idx)
        CsrScratch: scratch_d = strb_merge(scratch_q, wr_data, wr_strb);
        CsrCtrl: begin
          ctrl_d    = strb_merge(ctrl_q, wr_data, wr_strb);
          ctrl_wr_d = 1'b1;
        end
        // Clearing overrides any same-cycle increment.
        CsrCnt: begin
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      ctrl_q    <= CTRL_RST;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      ctrl_wr_q <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      ctrl_wr_q <= ctrl_wr_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_idx)
      CsrDfh:     rd_data = DFH_VALUE;
      CsrScratch: rd_data = scratch_q;
      CsrCtrl:    rd_data = ctrl_q;
      CsrStatus:  rd_data = status_i;
      CsrCnt:     rd_data = {rd_cnt_q, wr_cnt_q};
      default:    rd_data = '0;
    endcase
  end

  assign ctrl_o    = ctrl_q;
  assign ctrl_wr_o = ctrl_wr_q;

endmodule

// File: rtl/apf_csr_responder.sv
// apf_csr_responder: AXI4-Lite endpoint terminating one APF function port with a small CSR file.
//   clk, rst_n   clock, async active-low reset
//   csr_if       AXI-Lite slave link (DATA_W=64, ADDR_W)
//   status_i     live status, returned on STATUS reads
//   ctrl_o       current CTRL register value
//   ctrl_wr_o    one-cycle pulse when CTRL is written
// This module only owns channel handshakes and holding registers; storage is in apf_csr_regfile.
module apf_csr_responder
  import apf_csr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [63:0] DFH_VALUE = 64'h3000_0000_1000_0000,
  parameter logic [63:0] CTRL_RST  = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  ofs_fim_axi_lite_if.slave csr_if,
  input  logic [63:0]       status_i,
  output logic [63:0]       ctrl_o,
  output logic              ctrl_wr_o
);

  logic              aw_pend_q, aw_pend_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_pend_q, w_pend_d;
  logic [63:0]       w_data_q, w_data_d;
  logic [7:0]        w_strb_q, w_strb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              b_nocnt_q, b_nocnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [63:0]       rdata_q, rdata_d;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic [7:0]        wr_strb;
  csr_idx_e          wr_idx, rd_idx;
  logic [63:0]       rd_data;
  logic              unused_prot;

  assign unused_prot = ^{csr_if.awprot, csr_if.arprot};

  assign aw_hs = csr_if.awvalid & awready_q;
  assign w_hs  = csr_if.wvalid & wready_q;
  assign b_hs  = bvalid_q & csr_if.bready;
  assign ar_hs = csr_if.arvalid & arready_q;
  assign r_hs  = rvalid_q & csr_if.rready;

  // A beat handshaking this cycle counts as already held, so AW+W together commit at once.
  assign commit = !bvalid_q & (aw_pend_q | aw_hs) & (w_pend_q | w_hs);

  assign wr_addr = aw_pend_q ? aw_addr_q : csr_if.awaddr;
  assign wr_data = w_pend_q ? w_data_q : csr_if.wdata;
  assign wr_strb = w_pend_q ? w_strb_q : csr_if.wstrb;

  assign wr_idx = csr_decode(64'(wr_addr));
  assign rd_idx = csr_decode(64'(csr_if.araddr));

  always_comb begin
    aw_pend_d = aw_pend_q;
    aw_addr_d = aw_addr_q;
    w_pend_d  = w_pend_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    b_nocnt_d = b_nocnt_q;

    if (aw_hs) begin
      aw_pend_d = 1'b1;
      aw_addr_d = csr_if.awaddr;
    end
    if (w_hs) begin
      w_pend_d = 1'b1;
      w_data_d = csr_if.wdata;
      w_strb_d = csr_if.wstrb;
    end
    if (commit) begin
      bvalid_d  = 1'b1;
      bresp_d   = (wr_idx == CsrNone) ? RESP_SLVERR : RESP_OKAY;
      // The write that clears the counters must not count itself.
      b_nocnt_d = (wr_idx == CsrCnt);
    end
    // Pends stay set while B is outstanding, which holds the readies low.
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      b_nocnt_d = 1'b0;
    end

    awready_d = !aw_pend_d & !bvalid_d;
    wready_d  = !w_pend_d & !bvalid_d;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = (rd_idx == CsrNone) ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end

    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_pend_q <= 1'b0;
      aw_addr_q <= '0;
      w_pend_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      b_nocnt_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      aw_pend_q <= aw_pend_d;
      aw_addr_q <= aw_addr_d;
      w_pend_q  <= w_pend_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      b_nocnt_q <= b_nocnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign csr_if.awready = awready_q;
  assign csr_if.wready  = wready_q;
  assign csr_if.bvalid  = bvalid_q;
  assign csr_if.bresp   = bresp_q;
  assign csr_if.arready = arready_q;
  assign csr_if.rvalid  = rvalid_q;
  assign csr_if.rresp   = rresp_q;
  assign csr_if.rdata   = rdata_q;

  apf_csr_regfile #(
    .DFH_VALUE(DFH_VALUE),
    .CTRL_RST (CTRL_RST)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (commit),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_cnt_inc(b_hs & !b_nocnt_q),
    .rd_cnt_inc(r_hs),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .status_i  (status_i),
    .ctrl_o    (ctrl_o),
    .ctrl_wr_o (ctrl_wr_o)
  );

endmodule
